fir_ctrl_mc: RTL and testbench

- Parametrised successor to the single-channel FIR controller.
- Sequences a time-multiplexed MAC datapath for CHANNELS independent FIR channels of TAPS taps each.
- Owns per-channel circular-buffer write pointers, tap/coefficient address generation, MAC pipeline drain and output backpressure.
- Zero-fills the shared sample RAM after reset. Sits between the sample source and the shared coefficient ROM / sample RAM / accumulator datapath.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_ctrl_mc_if.sv | 36 +++
 rtl/fir_wptr_bank.sv | 39 +++
 rtl/fir_ctrl_mc.sv | 197 +++++++++++++++++++
 tb/tb_fir_ctrl_mc.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and address helpers for the multi-channel FIR controller.
// Address helpers return plain integers; callers truncate to their bus width.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // {ch, idx} with idx occupying the low idx_w bits.
    function automatic int unsigned addr_cat(input int unsigned ch,
                                             input int unsigned idx,
                                             input int unsigned idx_w);
        return (ch << idx_w) | idx;
    endfunction

    // (a - b) mod taps; taps must be a power of two.
    function automatic int unsigned mod_sub(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned taps);
        return (a - b) & (taps - 1);
    endfunction

endpackage

// File: rtl/fir_ctrl_mc_if.sv
// Handshake and RAM/ROM/MAC control bundle of the FIR controller.
// master = controller side, slave = sample source / datapath / sink side.
interface fir_ctrl_mc_if #(
    parameter int CH_W  = 1,
    parameter int TAP_W = 4
);
    localparam int AW = CH_W + TAP_W;

    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic            buf_we;
    logic            buf_wsel_zero;
    logic [AW-1:0]   buf_waddr;
    logic [AW-1:0]   buf_raddr;
    logic [AW-1:0]   coef_addr;
    logic            clr_acc;
    logic            acc_en;
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic            busy;

    modport master (
        input  in_valid, in_ch, out_ready,
        output in_ready, buf_we, buf_wsel_zero, buf_waddr, buf_raddr,
               coef_addr, clr_acc, acc_en, out_valid, out_ch, busy
    );

    modport slave (
        output in_valid, in_ch, out_ready,
        input  in_ready, buf_we, buf_wsel_zero, buf_waddr, buf_raddr,
               coef_addr, clr_acc, acc_en, out_valid, out_ch, busy
    );

endinterface

// File: rtl/fir_wptr_bank.sv
// Per-channel circular-buffer write pointers; each wraps naturally at 2**TAP_W.
// Read is a combinational mux by channel; increments take effect next cycle.
module fir_wptr_bank #(
    parameter int CHANNELS = 2,
    parameter int TAP_W    = 4,
    parameter int CH_W     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] inc_en_i,
    input  logic [CH_W-1:0]     rd_ch_i,
    output logic [TAP_W-1:0]    rd_ptr_o
);

    logic [TAP_W-1:0] ptr_q [CHANNELS];
    logic [TAP_W-1:0] ptr_d [CHANNELS];

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            ptr_d[c] = inc_en_i[c] ? ptr_q[c] + 1'b1 : ptr_q[c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) ptr_q[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) ptr_q[c] <= ptr_d[c];
        end
    end

    always_comb begin
        rd_ptr_o = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rd_ch_i == CH_W'(c)) rd_ptr_o = ptr_q[c];
        end
    end

endmodule

// File: rtl/fir_ctrl_mc.sv
// Time-multiplexed MAC sequencer for CHANNELS FIR channels of TAPS taps; zero-fills sample RAM after reset.
// Accept-to-result 1+TAPS+MAC_LAT+1 cycles; one sample in flight, result held until out_ready.
module fir_ctrl_mc
    import fir_pkg::*;
#(
    parameter int TAPS     = 16,
    parameter int CHANNELS = 2,
    parameter int MAC_LAT  = 2,
    parameter int TAP_W    = $clog2(TAPS),
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    fir_ctrl_mc_if.master bus
);

    localparam int AW   = CH_W + TAP_W;
    localparam int DR_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [AW-1:0]    SWEEP_LAST = AW'(CHANNELS * TAPS - 1);
    localparam logic [TAP_W-1:0] K_LAST     = TAP_W'(TAPS - 1);
    localparam logic [DR_W-1:0]  DRAIN_LAST = DR_W'(MAC_LAT - 1);
    localparam logic [CH_W:0]    CH_LIM     = (CH_W + 1)'(CHANNELS);

    state_e            state_q, state_d;
    logic [AW-1:0]     sweep_q, sweep_d;
    logic [TAP_W-1:0]  k_q, k_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              wptr_adv;
    logic [CHANNELS-1:0] inc_en;
    logic [TAP_W-1:0]  wptr_rd;
    logic              ch_ok;

    logic              in_ready_q, in_ready_d;
    logic              buf_we_q, buf_we_d;
    logic              wsel_zero_q, wsel_zero_d;
    logic [AW-1:0]     waddr_q, waddr_d;
    logic [AW-1:0]     raddr_q, raddr_d;
    logic [AW-1:0]     coef_q, coef_d;
    logic              clr_acc_q, clr_acc_d;
    logic              acc_en_q, acc_en_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic              busy_q, busy_d;

    assign ch_ok = ({1'b0, bus.in_ch} < CH_LIM);

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            inc_en[c] = wptr_adv && (cur_ch_q == CH_W'(c));
        end
    end

    fir_wptr_bank #(
        .CHANNELS (CHANNELS),
        .TAP_W    (TAP_W),
        .CH_W     (CH_W)
    ) u_wptr (
        .clk      (clk),
        .rst      (rst),
        .inc_en_i (inc_en),
        .rd_ch_i  (cur_ch_d),
        .rd_ptr_o (wptr_rd)
    );

    // Next-state logic. The sweep only advances once the first zero-write
    // strobe is actually on the bus, so address 0 is never skipped after reset.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        k_d      = k_q;
        drain_d  = drain_q;
        cur_ch_d = cur_ch_q;
        wptr_adv = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (buf_we_q) begin
                    if (sweep_q == SWEEP_LAST) begin
                        sweep_d = '0;
                        state_d = ST_WAIT;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.in_valid && ch_ok) begin
                    cur_ch_d = bus.in_ch;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                k_d     = '0;
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                k_d = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    drain_d = '0;
                    state_d = (MAC_LAT == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = ST_DONE;
                else                       drain_d = drain_q + 1'b1;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    wptr_adv = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = '0;
                k_d     = '0;
            end
        endcase
    end

    // Output decode of the next state, registered alongside it.
    always_comb begin
        in_ready_d  = (state_d == ST_WAIT);
        clr_acc_d   = (state_d == ST_WAIT);
        busy_d      = (state_d != ST_WAIT);
        buf_we_d    = (state_d == ST_INIT) || (state_d == ST_LOAD);
        wsel_zero_d = (state_d == ST_INIT);
        acc_en_d    = (state_d == ST_COMPUTE);
        out_valid_d = (state_d == ST_DONE);
        out_ch_d    = (state_d == ST_DONE) ? cur_ch_d : out_ch_q;
        waddr_d     = '0;
        raddr_d     = '0;
        coef_d      = '0;
        if (state_d == ST_INIT) begin
            waddr_d = sweep_d;
        end else if (state_d == ST_LOAD) begin
            waddr_d = AW'(addr_cat(32'(cur_ch_d), 32'(wptr_rd), TAP_W));
        end
        if (state_d == ST_COMPUTE) begin
            coef_d  = AW'(addr_cat(32'(cur_ch_d), 32'(k_d), TAP_W));
            raddr_d = AW'(addr_cat(32'(cur_ch_d),
                                   mod_sub(32'(wptr_rd), 32'(k_d), TAPS), TAP_W));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            cur_ch_q    <= '0;
            in_ready_q  <= 1'b0;
            buf_we_q    <= 1'b0;
            wsel_zero_q <= 1'b0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            coef_q      <= '0;
            clr_acc_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            k_q         <= k_d;
            drain_q     <= drain_d;
            cur_ch_q    <= cur_ch_d;
            in_ready_q  <= in_ready_d;
            buf_we_q    <= buf_we_d;
            wsel_zero_q <= wsel_zero_d;
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            coef_q      <= coef_d;
            clr_acc_q   <= clr_acc_d;
            acc_en_q    <= acc_en_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.buf_we        = buf_we_q;
    assign bus.buf_wsel_zero = wsel_zero_q;
    assign bus.buf_waddr     = waddr_q;
    assign bus.buf_raddr     = raddr_q;
    assign bus.coef_addr     = coef_q;
    assign bus.clr_acc       = clr_acc_q;
    assign bus.acc_en        = acc_en_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_ch        = out_ch_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_fir_ctrl_mc.sv
// Randomized bench for fir_ctrl_mc against a per-sample address/timing model.
// The model keeps only per-channel pointers and derives every address from the FIR rules.
module tb_fir_ctrl_mc;

    localparam int TAPS     = 16;
    localparam int CHANNELS = 2;
    localparam int MAC_LAT  = 2;
    localparam int TAP_W    = 4;
    localparam int CH_W     = 1;
    localparam int LAT      = 1 + TAPS + MAC_LAT + 1;

    logic clk = 1'b0;
    logic rst;

    fir_ctrl_mc_if #(.CH_W(CH_W), .TAP_W(TAP_W)) bus ();

    fir_ctrl_mc #(
        .TAPS     (TAPS),
        .CHANNELS (CHANNELS),
        .MAC_LAT  (MAC_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned m_wptr [CHANNELS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({bus.buf_we, bus.buf_wsel_zero, bus.acc_en, bus.clr_acc,
                    bus.in_ready, bus.out_valid});
    endfunction

    // Called right after reset release; handshakes are driven to prove they are ignored.
    task automatic run_sweep();
        int w;
        bus.in_valid  = 1'b1;
        bus.in_ch     = '0;
        bus.out_ready = 1'b1;
        w = 0;
        while (!bus.buf_we && w < 4) begin
            tick();
            w++;
        end
        chk("sweep_start", 32'(bus.buf_we), 32'd1);
        for (int a = 0; a < CHANNELS * TAPS; a++) begin
            chk("sweep_addr", 32'(bus.buf_waddr), 32'(a));
            chk("sweep_ctl", 32'({bus.buf_we, bus.buf_wsel_zero, bus.in_ready, bus.out_valid}),
                32'b1100);
            tick();
        end
        chk("sweep_end_we", 32'(bus.buf_we), 32'd0);
        chk("sweep_end_rdy", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < CHANNELS; c++) m_wptr[c] = 0;
    endtask

    task automatic do_sample(input int ch, input int stall, input int abort_k, output bit aborted);
        int unsigned wp;
        int unsigned base;
        int unsigned t0;
        int w;
        wp      = m_wptr[ch];
        base    = 32'(ch) * TAPS;
        aborted = 1'b0;

        w = 0;
        while (!bus.in_ready && w < 8) begin
            tick();
            w++;
        end
        chk("wait_rdy", 32'(bus.in_ready), 32'd1);
        chk("wait_clr", 32'({bus.clr_acc, bus.busy}), 32'b10);
        if (!bus.in_ready) return;

        bus.in_valid = 1'b1;
        bus.in_ch    = CH_W'(ch);
        t0 = cyc;
        tick();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_ch     = CH_W'($urandom_range(0, CHANNELS - 1));
        bus.out_ready = 1'($urandom_range(0, 1));

        chk("load_ctl", 32'({bus.buf_we, bus.buf_wsel_zero, bus.in_ready}), 32'b100);
        chk("load_waddr", 32'(bus.buf_waddr), base + wp);
        tick();

        for (int k = 0; k < TAPS; k++) begin
            if (k == abort_k) begin
                rst = 1'b0;
                #1;
                chk("arst_strobes", strobes(), 32'd0);
                aborted      = 1'b1;
                bus.in_valid = 1'b0;
                return;
            end
            chk("mac_ctl", 32'({bus.acc_en, bus.in_ready, bus.buf_we, bus.busy}), 32'b1001);
            chk("mac_coef", 32'(bus.coef_addr), base + 32'(k));
            chk("mac_raddr", 32'(bus.buf_raddr), base + ((wp + TAPS - 32'(k)) % TAPS));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end

        w = 0;
        while (!bus.out_valid && w < MAC_LAT + 4) begin
            chk("drain_idle", 32'({bus.acc_en, bus.in_ready}), 32'd0);
            tick();
            w++;
        end
        chk("latency", cyc - t0, 32'(LAT));

        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            chk("stall_ctl", 32'({bus.out_valid, bus.in_ready}), 32'b10);
            chk("stall_ch", 32'(bus.out_ch), 32'(ch));
            tick();
        end
        chk("done_ctl", 32'({bus.out_valid, bus.in_ready}), 32'b10);
        chk("done_ch", 32'(bus.out_ch), 32'(ch));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("post_hs", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        m_wptr[ch] = (wp + 1) % TAPS;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_strobes", strobes(), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);

        rst = 1'b1;
        run_sweep();

        // single sample, backpressure, interleave
        do_sample(0, 0, -1, ab);
        do_sample(0, 7, -1, ab);
        do_sample(1, 0, -1, ab);
        do_sample(0, 0, -1, ab);
        do_sample(1, 2, -1, ab);

        // ch0 pointer wraps past TAPS-1
        for (int i = 0; i < 17; i++) do_sample(0, $urandom_range(0, 3), -1, ab);

        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_sample($urandom_range(0, CHANNELS - 1), $urandom_range(0, 4), -1, ab);
        end

        // reset during compute
        do_sample(1, 0, 5, ab);
        chk("abort_hit", 32'(ab), 32'd1);
        repeat (2) tick();
        chk("arst_hold", strobes(), 32'd0);
        rst = 1'b1;
        run_sweep();
        do_sample(1, 0, -1, ab);
        do_sample(0, 1, -1, ab);
        do_sample(1, 0, -1, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
